// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- 2**ADDR_W x DATA_W register file, one write port, two
// independent registered read ports (A and B) with one-cycle latency.
//
// Register 0 is hardwired to read zero; writes to it are dropped.
// A request sampled at a rising edge produces rdata/rvalid right after that
// edge. rvalid tracks the request one edge later; rdata holds its last value
// while no request is made.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read that hits the address being written in the same cycle
//               returns the incoming wdata (write-first).
//   undefined : such a read returns the prior register contents (read-first).
//
// clr is a synchronous, active-low clear of all storage and outputs.
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rreq_a,
    input  logic              rreq_b,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_a,
    output logic              rvalid_b
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic              r_rvalid_a;
    logic              r_rvalid_b;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // A write to address 0 is dropped so register 0 keeps reading zero.
    assign w_wr_en = we && (waddr != '0);

    // Read-data selection, with optional same-cycle write forwarding.
    always_comb begin
        w_rd_a = r_mem[raddr_a];
        w_rd_b = r_mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (waddr == raddr_a)) begin
            w_rd_a = wdata;
        end
        if (w_wr_en && (waddr == raddr_b)) begin
            w_rd_b = wdata;
        end
`endif
    end

    // Storage array: synchronous clear, single write port.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port A: capture data on request, valid follows the request.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_rdata_a  <= '0;
            r_rvalid_a <= 1'b0;
        end else begin
            r_rvalid_a <= rreq_a;
            if (rreq_a) begin
                r_rdata_a <= w_rd_a;
            end
        end
    end

    // Read port B: independent copy of port A.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_rdata_b  <= '0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_b <= rreq_b;
            if (rreq_b) begin
                r_rdata_b <= w_rd_b;
            end
        end
    end

    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile -- self-checking bench for regfile (default 32x32).
// A plain array model predicts outputs every cycle; directed scenarios add
// hand-computed literal expectations. Honours REGFILE_BYPASS_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 2**AW;

    logic          clk = 1'b0;
    logic          clr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rreq_a, rreq_b;
    logic [AW-1:0] raddr_a, raddr_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b;

    int total = 0;
    int bad   = 0;

    // model state
    logic [DW-1:0] m_mem [NREG];
    logic [DW-1:0] m_rd_a, m_rd_b;
    logic          m_rv_a, m_rv_b;
    bit            m_defined = 0;

    regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .clr      (clr),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .rreq_a   (rreq_a),
        .rreq_b   (rreq_b),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read of addr returns this cycle given the current write inputs.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
        if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == addr) return wdata;
`endif
        return m_mem[addr];
    endfunction

    // One clock: predict from current inputs, take the edge, compare, commit.
    task automatic cycle();
        logic [DW-1:0] na, nb;
        logic          va, vb;
        na = m_rd_a; nb = m_rd_b;
        va = 1'b0;   vb = 1'b0;
        if (!clr) begin
            na = '0; nb = '0;
        end else begin
            va = rreq_a;
            vb = rreq_b;
            if (rreq_a) na = model_read(raddr_a);
            if (rreq_b) nb = model_read(raddr_b);
        end
        @(posedge clk);
        #1;
        if (!clr) begin
            for (int i = 0; i < NREG; i++) m_mem[i] = '0;
            m_defined = 1;
        end else if (we && waddr != 0) begin
            m_mem[waddr] = wdata;
        end
        m_rd_a = na; m_rd_b = nb; m_rv_a = va; m_rv_b = vb;
        if (m_defined) begin
            check("model rdata_a",  rdata_a,  m_rd_a);
            check("model rdata_b",  rdata_b,  m_rd_b);
            check("model rvalid_a", {31'd0, rvalid_a}, {31'd0, m_rv_a});
            check("model rvalid_b", {31'd0, rvalid_b}, {31'd0, m_rv_b});
        end
    endtask

    task automatic idle();
        clr = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        rreq_a = 1'b0; rreq_b = 1'b0; raddr_a = '0; raddr_b = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle(); we = 1'b1; waddr = a; wdata = d;
        cycle();
    endtask

    initial begin
        int nvalid;
        logic [DW-1:0] exp29;
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        m_rd_a = '0; m_rd_b = '0; m_rv_a = 1'b0; m_rv_b = 1'b0;
        idle();
        @(negedge clk);

        // reset
        clr = 1'b0;
        cycle();
        cycle();
        check("reset rdata_a",  rdata_a, 32'h0);
        check("reset rvalid_a", {31'd0, rvalid_a}, 32'h0);

        // read after reset
        idle(); rreq_a = 1'b1; raddr_a = 5'd7;
        cycle();
        check("rst read rdata_a",  rdata_a, 32'h0);
        check("rst read rvalid_a", {31'd0, rvalid_a}, 32'h1);

        // write then dual read same address
        wr(5'd5, 32'hDEADBEEF);
        idle(); rreq_a = 1'b1; rreq_b = 1'b1; raddr_a = 5'd5; raddr_b = 5'd5;
        cycle();
        check("dual rdata_a",  rdata_a, 32'hDEADBEEF);
        check("dual rdata_b",  rdata_b, 32'hDEADBEEF);
        check("dual rvalid_b", {31'd0, rvalid_b}, 32'h1);

        // write to register 0 is discarded
        wr(5'd0, 32'hFFFFFFFF);
        idle(); rreq_a = 1'b1; raddr_a = 5'd0;
        cycle();
        check("reg0 rdata_a", rdata_a, 32'h0);

        // same-cycle write/read collision
        wr(5'd3, 32'h11);
        idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h22; rreq_a = 1'b1; raddr_a = 5'd3;
        cycle();
`ifdef REGFILE_BYPASS_EN
        exp29 = 32'h22;
`else
        exp29 = 32'h11;
`endif
        check("collision rdata_a", rdata_a, exp29);
        idle(); rreq_a = 1'b1; raddr_a = 5'd3;
        cycle();
        check("post collision rdata_a", rdata_a, 32'h22);

        // reset overrides write and read in the same cycle
        idle(); clr = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        rreq_b = 1'b1; raddr_b = 5'd9;
        cycle();
        check("rst drop rvalid_b", {31'd0, rvalid_b}, 32'h0);
        check("rst drop rdata_b",  rdata_b, 32'h0);
        idle(); rreq_b = 1'b1; raddr_b = 5'd9;
        cycle();
        check("reg9 after rst", rdata_b, 32'h0);

        // three-cycle burst then hold
        wr(5'd4, 32'hA5A5);
        wr(5'd6, 32'h1234);
        nvalid = 0;
        idle(); rreq_a = 1'b1;
        raddr_a = 5'd4; cycle(); nvalid += int'(rvalid_a);
        raddr_a = 5'd6; cycle(); nvalid += int'(rvalid_a);
        raddr_a = 5'd4; cycle(); nvalid += int'(rvalid_a);
        idle(); raddr_a = 5'd6;
        cycle(); nvalid += int'(rvalid_a);
        check("burst hold rdata_a", rdata_a, 32'hA5A5);
        cycle(); nvalid += int'(rvalid_a);
        check("burst valid count", nvalid, 32'd3);
        check("burst hold2 rdata_a", rdata_a, 32'hA5A5);

        // randomized traffic, narrow address window half the time to force hits
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] mask;
            mask = ($urandom_range(0, 1) == 0) ? 5'h03 : 5'h1F;
            clr     = ($urandom_range(0, 99) != 0);
            we      = ($urandom_range(0, 2) != 0);
            waddr   = AW'($urandom) & mask;
            wdata   = $urandom;
            rreq_a  = ($urandom_range(0, 3) != 0);
            rreq_b  = ($urandom_range(0, 3) != 0);
            raddr_a = AW'($urandom) & mask;
            raddr_b = AW'($urandom) & mask;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
